// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: opcode constants,
// the controller state encoding and the 16-bit datapath word type.
package mem_stage_ctrl_pkg;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;

    typedef logic [15:0] word_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // A load is recognised purely by its opcode field.
    function automatic logic is_load(input word_t ir);
        return ir[15:12] == OP_LW;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline boundary register. Loads a new bundle on i_load, drops
// valid once the consumer takes it, and holds everything while stalled.
module mem_wb_reg
    import mem_stage_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  logic  i_ready,
    input  word_t i_ir,
    input  word_t i_wb_data,
    input  logic  i_reg_wr_en,
    input  logic  i_carry,
    input  logic  i_zero,
    output logic  o_valid,
    output word_t o_ir,
    output word_t o_wb_data,
    output logic  o_reg_wr_en,
    output logic  o_carry,
    output logic  o_zero
);

    logic  r_valid;
    word_t r_ir;
    word_t r_wb_data;
    logic  r_reg_wr_en;
    logic  r_carry;
    logic  r_zero;

    // Bundle register: load wins over consume; otherwise hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_ir        <= '0;
            r_wb_data   <= '0;
            r_reg_wr_en <= 1'b0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
        end else if (i_load) begin
            r_valid     <= 1'b1;
            r_ir        <= i_ir;
            r_wb_data   <= i_wb_data;
            r_reg_wr_en <= i_reg_wr_en;
            r_carry     <= i_carry;
            r_zero      <= i_zero;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_ir        = r_ir;
    assign o_wb_data   = r_wb_data;
    assign o_reg_wr_en = r_reg_wr_en;
    assign o_carry     = r_carry;
    assign o_zero      = r_zero;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: takes the EX/MEM bundle, runs loads/stores over a
// variable-latency req/ack data-memory port and registers the MEM/WB bundle.
// Optional ack watchdog with dmem_err output: define MEM_STAGE_TIMEOUT_EN.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       IR_in,
    input  logic [15:0]       D1_in,
    input  logic [15:0]       alu_out_in,
    input  logic              reg_wr_en_in,
    input  logic              mem_wr_en_in,
    input  logic              carryin,
    input  logic              zeroin,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
`ifdef MEM_STAGE_TIMEOUT_EN
    output logic              dmem_err,
`endif
    input  logic              dmem_ack,
    input  logic [15:0]       dmem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       IR_out,
    output logic [15:0]       wb_data_out,
    output logic              reg_wr_en_out,
    output logic              carryout,
    output logic              zeroout
);

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    word_t             r_wdata;
    word_t             r_cap_ir;
    word_t             r_cap_alu;
    logic              r_cap_rw;
    logic              r_cap_c;
    logic              r_cap_z;

    logic  w_out_valid;
    logic  w_out_free;
    logic  w_capture;
    logic  w_is_mem;
    logic  w_ack_done;
    logic  w_timeout;
    logic  w_access_end;
    logic  w_emit;
    word_t w_nx_ir;
    word_t w_nx_wb;
    logic  w_nx_rw;
    logic  w_nx_c;
    logic  w_nx_z;

    // Upstream may only hand over a bundle when no access is outstanding
    // and the output slot is empty or being drained this cycle.
    assign w_out_free   = !w_out_valid || out_ready;
    assign in_ready     = rst && (r_state == ST_IDLE) && w_out_free;
    assign w_capture    = in_valid && in_ready;
    assign w_is_mem     = mem_wr_en_in || is_load(IR_in);
    assign w_ack_done   = (r_state == ST_ACCESS) && dmem_ack;
    assign w_access_end = w_ack_done || w_timeout;
    assign w_emit       = (w_capture && !w_is_mem) || w_access_end;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int                 TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_timeout = (r_state == ST_ACCESS) && !dmem_ack && (r_tmo_cnt == TMO_LAST);
    assign dmem_err  = r_err;

    // Watchdog: counts ACCESS cycles without ack; dmem_err pulses once on expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state != ST_ACCESS) begin
                r_tmo_cnt <= '0;
            end else if (!dmem_ack) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next MEM/WB bundle: straight from the inputs for ALU ops, from the
    // captured bundle plus read data when an access completes.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a value unassigned, which would infer a latch.
        w_nx_ir = IR_in;
        w_nx_wb = alu_out_in;
        w_nx_rw = reg_wr_en_in;
        w_nx_c  = carryin;
        w_nx_z  = zeroin;
        if (r_state == ST_ACCESS) begin
            w_nx_ir = r_cap_ir;
            w_nx_c  = r_cap_c;
            w_nx_z  = r_cap_z;
            if (w_timeout || r_we) begin
                // Stores and abandoned accesses never write the register file.
                w_nx_wb = r_cap_alu;
                w_nx_rw = 1'b0;
            end else begin
                w_nx_wb = dmem_rdata;
                w_nx_rw = r_cap_rw;
                w_nx_z  = (dmem_rdata == 16'h0000);
            end
        end
    end

    // Access FSM: launches the memory request and holds it stable until ack.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cap_ir  <= '0;
            r_cap_alu <= '0;
            r_cap_rw  <= 1'b0;
            r_cap_c   <= 1'b0;
            r_cap_z   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture && w_is_mem) begin
                        r_state   <= ST_ACCESS;
                        r_req     <= 1'b1;
                        r_we      <= mem_wr_en_in;
                        r_addr    <= alu_out_in[ADDR_W-1:0];
                        r_wdata   <= D1_in;
                        r_cap_ir  <= IR_in;
                        r_cap_alu <= alu_out_in;
                        r_cap_rw  <= reg_wr_en_in;
                        r_cap_c   <= carryin;
                        r_cap_z   <= zeroin;
                    end
                end
                ST_ACCESS: begin
                    if (w_access_end) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign out_valid  = w_out_valid;

    mem_wb_reg u_mem_wb (
        .clk         (clk),
        .rst_n       (rst),
        .i_load      (w_emit),
        .i_ready     (out_ready),
        .i_ir        (w_nx_ir),
        .i_wb_data   (w_nx_wb),
        .i_reg_wr_en (w_nx_rw),
        .i_carry     (w_nx_c),
        .i_zero      (w_nx_z),
        .o_valid     (w_out_valid),
        .o_ir        (IR_out),
        .o_wb_data   (wb_data_out),
        .o_reg_wr_en (reg_wr_en_out),
        .o_carry     (carryout),
        .o_zero      (zeroout)
    );

endmodule
